operand_forward_unit: RTL and testbench



---
 rtl/fwd_pkg.sv | 12 +
 rtl/fwd_operand_mux.sv | 46 ++++
 rtl/operand_forward_unit.sv | 90 +++++++++
 tb/tb_operand_forward_unit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: forwarding source encoding and default widths for operand_forward_unit
package fwd_pkg;
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EX  = 2'd3
  } fwd_src_e;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int N_RD_DEF   = 2;
endpackage

// File: rtl/fwd_operand_mux.sv
// fwd_operand_mux: one operand's youngest-first forwarding select plus load-use/scoreboard hazard
// Ports: rs/rf_rdata in, EX/MEM/WB write ports in, busy (scoreboard bit for rs) in; data/sel/hazard out.
module fwd_operand_mux
  import fwd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] rs,
  input  logic [DATA_W-1:0] rf_rdata,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_wr_en,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_wr_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              busy,
  input  logic              mc_done,
  input  logic [ADDR_W-1:0] mc_done_rd,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        sel,
  output logic              hazard
);
  logic nz, ex_hit, mem_hit, wb_hit, load_use, sb_hit;
  fwd_src_e src;
  always_comb begin
    nz       = |rs;
    ex_hit   = ex_wr_en && !ex_is_load && ex_rd == rs;
    mem_hit  = mem_wr_en && mem_rd == rs;
    wb_hit   = wb_wr_en && wb_rd == rs;
    src      = !nz ? FWD_RF : ex_hit ? FWD_EX : mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
    data     = !nz ? '0 : src == FWD_EX ? ex_result : src == FWD_MEM ? mem_result :
               src == FWD_WB ? wb_data : rf_rdata;
    sel      = src;
    // a load in EX has no data yet; its consumer waits one cycle and picks it up from MEM
    load_use = id_valid && nz && ex_wr_en && ex_is_load && ex_rd == rs;
    // a multi-cycle result completing this cycle arrives on wb_data, so it is bypassed
    sb_hit   = id_valid && nz && busy && !(mc_done && mc_done_rd == rs);
    hazard   = load_use || sb_hit;
  end
endmodule

// File: rtl/operand_forward_unit.sv
// operand_forward_unit: ID-stage operand forwarding, load-use and multi-cycle scoreboard stall
// Ports: id_rs/rf_rdata and EX/MEM/WB/mc_* pipeline inputs; op_data, fwd_sel, id_stall, busy_vec out.
// FWD_STATS_EN adds saturating stall_cnt and fwd_cnt outputs.
module operand_forward_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_RD   = N_RD_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [N_RD*ADDR_W-1:0] id_rs,
  input  logic [N_RD*DATA_W-1:0] rf_rdata,
  input  logic                   ex_wr_en,
  input  logic                   ex_is_load,
  input  logic [ADDR_W-1:0]      ex_rd,
  input  logic [DATA_W-1:0]      ex_result,
  input  logic                   mem_wr_en,
  input  logic [ADDR_W-1:0]      mem_rd,
  input  logic [DATA_W-1:0]      mem_result,
  input  logic                   wb_wr_en,
  input  logic [ADDR_W-1:0]      wb_rd,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   mc_issue,
  input  logic [ADDR_W-1:0]      mc_rd,
  input  logic                   mc_done,
  input  logic [ADDR_W-1:0]      mc_done_rd,
  output logic [N_RD*DATA_W-1:0] op_data,
  output logic [N_RD*2-1:0]      fwd_sel,
  output logic                   id_stall,
  output logic [2**ADDR_W-1:0]   busy_vec
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            fwd_cnt
`endif
);
  logic [2**ADDR_W-1:0] busy_q, busy_d, busy_eff;
  logic [N_RD-1:0] haz;
  // reset must mask the scoreboard immediately, not only after the edge
  assign busy_eff = rst ? '0 : busy_q;
  assign busy_vec = busy_q;
  assign id_stall = |haz;
  for (genvar g = 0; g < N_RD; g++) begin : g_op
    fwd_operand_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux (
      .id_valid  (id_valid),
      .rs        (id_rs[g*ADDR_W +: ADDR_W]),
      .rf_rdata  (rf_rdata[g*DATA_W +: DATA_W]),
      .ex_wr_en  (ex_wr_en),
      .ex_is_load(ex_is_load),
      .ex_rd     (ex_rd),
      .ex_result (ex_result),
      .mem_wr_en (mem_wr_en),
      .mem_rd    (mem_rd),
      .mem_result(mem_result),
      .wb_wr_en  (wb_wr_en),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .busy      (busy_eff[id_rs[g*ADDR_W +: ADDR_W]]),
      .mc_done   (mc_done),
      .mc_done_rd(mc_done_rd),
      .data      (op_data[g*DATA_W +: DATA_W]),
      .sel       (fwd_sel[g*2 +: 2]),
      .hazard    (haz[g])
    );
  end
  // clear before set so a same-cycle done/issue to one register leaves it busy
  always_comb begin
    busy_d = busy_q;
    if (mc_done) busy_d[mc_done_rd] = 1'b0;
    if (mc_issue && !id_stall) busy_d[mc_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk) busy_q <= rst ? '0 : busy_d;
`ifdef FWD_STATS_EN
  logic [31:0] stall_q, stall_d, fwd_q, fwd_d;
  always_comb begin
    stall_d = (id_stall && ~&stall_q) ? stall_q + 32'd1 : stall_q;
    fwd_d   = (|fwd_sel && !id_stall && ~&fwd_q) ? fwd_q + 32'd1 : fwd_q;
  end
  always_ff @(posedge clk) begin
    stall_q <= rst ? '0 : stall_d;
    fwd_q   <= rst ? '0 : fwd_d;
  end
  assign stall_cnt = stall_q;
  assign fwd_cnt   = fwd_q;
`endif
endmodule

// File: tb/tb_operand_forward_unit.sv
// tb_operand_forward_unit: directed vectors with a queued scoreboard and negedge monitor
module tb_operand_forward_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic id_valid, ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en, mc_issue, mc_done;
  logic [9:0] id_rs;
  logic [63:0] rf_rdata, op_data;
  logic [4:0] ex_rd, mem_rd, wb_rd, mc_rd, mc_done_rd;
  logic [31:0] ex_result, mem_result, wb_data, busy_vec;
  logic [3:0] fwd_sel;
  logic id_stall;
  int tests = 0, fails = 0;
`ifdef FWD_STATS_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif
  typedef struct {
    string name;
    logic [63:0] op;
    logic [3:0] sel;
    logic stall;
    logic [31:0] busy;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  operand_forward_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .rf_rdata(rf_rdata),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_done(mc_done), .mc_done_rd(mc_done_rd),
    .op_data(op_data), .fwd_sel(fwd_sel), .id_stall(id_stall), .busy_vec(busy_vec)
`ifdef FWD_STATS_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );
  task automatic cmp(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp({e.name, ".op_data"}, op_data, e.op);
      cmp({e.name, ".fwd_sel"}, {60'd0, fwd_sel}, {60'd0, e.sel});
      cmp({e.name, ".id_stall"}, {63'd0, id_stall}, {63'd0, e.stall});
      cmp({e.name, ".busy_vec"}, {32'd0, busy_vec}, {32'd0, e.busy});
    end
  end
  task automatic expect_v(input string n, input logic [63:0] op, input logic [3:0] sel,
                          input logic st, input logic [31:0] b);
    q.push_back('{n, op, sel, st, b});
  endtask
  task automatic idle();
    id_valid = 0; id_rs = '0; rf_rdata = '0;
    ex_wr_en = 0; ex_is_load = 0; ex_rd = '0; ex_result = '0;
    mem_wr_en = 0; mem_rd = '0; mem_result = '0;
    wb_wr_en = 0; wb_rd = '0; wb_data = '0;
    mc_issue = 0; mc_rd = '0; mc_done = 0; mc_done_rd = '0;
  endtask
  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask
  initial begin
    idle();
    @(posedge clk);
    next();
    expect_v("reset", 64'd0, 4'd0, 1'b0, 32'd0);
    next(); rst = 0;
    id_valid = 1; id_rs = {5'd6, 5'd5}; rf_rdata = {32'h66, 32'h55};
    ex_wr_en = 1; ex_rd = 5; ex_result = 32'h11;
    mem_wr_en = 1; mem_rd = 5; mem_result = 32'h22;
    expect_v("ex_over_mem", {32'h66, 32'h11}, 4'b0011, 1'b0, 32'd0);
    next();
    id_valid = 1; id_rs = {5'd7, 5'd1}; rf_rdata = {32'h0, 32'h1};
    wb_wr_en = 1; wb_rd = 7; wb_data = 32'hABCD;
    expect_v("wb_bypass", {32'hABCD, 32'h1}, 4'b0100, 1'b0, 32'd0);
    next();
    id_valid = 1; id_rs = {5'd0, 5'd3}; rf_rdata = {32'h77, 32'h33};
    ex_wr_en = 1; ex_is_load = 1; ex_rd = 3; ex_result = 32'hDEAD;
    expect_v("load_use", {32'h0, 32'h33}, 4'b0000, 1'b1, 32'd0);
    next();
    id_valid = 1; id_rs = {5'd0, 5'd3}; rf_rdata = {32'h77, 32'h33};
    mem_wr_en = 1; mem_rd = 3; mem_result = 32'h55;
    wb_wr_en = 1; wb_rd = 3; wb_data = 32'h99;
    expect_v("load_mem_fwd", {32'h0, 32'h55}, 4'b0010, 1'b0, 32'd0);
    next();
    id_valid = 1; id_rs = {5'd2, 5'd1}; rf_rdata = {32'h2, 32'h1};
    mc_issue = 1; mc_rd = 9;
    expect_v("mc_issue9", {32'h2, 32'h1}, 4'b0000, 1'b0, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      next();
      id_valid = 1; id_rs = {5'd0, 5'd9}; rf_rdata = {32'h0, 32'h90};
      if (c == 2) begin mc_issue = 1; mc_rd = 12; end
      expect_v($sformatf("sb_stall_c%0d", c), {32'h0, 32'h90}, 4'b0000, 1'b1, 32'h200);
    end
    next();
    id_valid = 1; id_rs = {5'd0, 5'd9}; rf_rdata = {32'h0, 32'h90};
    mc_done = 1; mc_done_rd = 9; wb_wr_en = 1; wb_rd = 9; wb_data = 32'h99;
    expect_v("mc_done_bypass", {32'h0, 32'h99}, 4'b0001, 1'b0, 32'h200);
    next();
    mc_issue = 1; mc_rd = 4;
    expect_v("busy9_cleared", 64'd0, 4'd0, 1'b0, 32'd0);
    next();
    id_rs = {5'd0, 5'd4};
    mc_done = 1; mc_done_rd = 4; mc_issue = 1; mc_rd = 4;
    expect_v("done_issue_same", 64'd0, 4'd0, 1'b0, 32'h10);
    next();
    id_valid = 1; id_rs = {5'd0, 5'd4}; rf_rdata = {32'h0, 32'h44};
    expect_v("set_wins", {32'h0, 32'h44}, 4'b0000, 1'b1, 32'h10);
    next();
    id_valid = 1; id_rs = {5'd0, 5'd0}; rf_rdata = {32'hFFFF, 32'hEEEE};
    ex_wr_en = 1; ex_is_load = 1; ex_rd = 0; ex_result = 32'h1;
    mem_wr_en = 1; mem_rd = 0; mem_result = 32'h2;
    wb_wr_en = 1; wb_rd = 0; wb_data = 32'h3;
    mc_issue = 1; mc_rd = 0;
    expect_v("r0_zero", 64'd0, 4'd0, 1'b0, 32'h10);
    next();
    id_valid = 1; id_rs = {5'd0, 5'd0}; ex_wr_en = 1; ex_rd = 0; ex_result = 32'h5;
    mc_issue = 1; mc_rd = 9;
    expect_v("r0_alu_ignored", 64'd0, 4'd0, 1'b0, 32'h10);
    next(); rst = 1;
    id_valid = 1; id_rs = {5'd9, 5'd4}; rf_rdata = {32'h9, 32'h4};
    expect_v("stall_masked_in_rst", {32'h9, 32'h4}, 4'b0000, 1'b0, 32'h210);
    next(); rst = 0;
    id_valid = 1; id_rs = {5'd9, 5'd4}; rf_rdata = {32'h9, 32'h4};
    mc_done = 1; mc_done_rd = 4;
    expect_v("after_rst", {32'h9, 32'h4}, 4'b0000, 1'b0, 32'd0);
`ifdef FWD_STATS_EN
    @(negedge clk);
    cmp("stall_cnt_rst", {32'd0, stall_cnt}, 64'd0);
    cmp("fwd_cnt_rst", {32'd0, fwd_cnt}, 64'd0);
`endif
    next();
    id_valid = 1; id_rs = {5'd9, 5'd4}; rf_rdata = {32'h9, 32'h4};
    expect_v("done_on_cleared_noop", {32'h9, 32'h4}, 4'b0000, 1'b0, 32'd0);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
